// File: rtl/trig_debug_capture.sv
// Trigger debug word builder: edge-detects and stretches event strobes, packs data/timestamp/hit count/state,
// and freezes the word a programmable number of cycles after a qualified event so slow readback can inspect it.
module trig_debug_capture #(
  parameter int STRETCH = 4,
  parameter int HOLDOFF = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  event_i,
  input  logic [23:0] data_i,
  input  logic [7:0]  trig_mask_i,
  input  logic        arm_i,
  output logic [52:0] debug_o,
  output logic        frozen_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    POST   = 2'b10,
    FROZEN = 2'b11
  } state_t;

  localparam logic [3:0]  STRETCH_LOAD = 4'(STRETCH);
  localparam logic [15:0] HOLD_LOAD    = (HOLDOFF == 0) ? 16'd0 : 16'(HOLDOFF - 1);

  state_t      state;
  logic [7:0]  ev_r;
  logic [7:0]  ev_rr;
  logic [23:0] data_r;
  logic [23:0] data_rr;
  logic [7:0]  rise;
  logic        qual;
  logic [3:0]  stretch_cnt [8];
  logic [7:0]  stretched;
  logic [15:0] ts;
  logic [15:0] hold_cnt;
  logic [2:0]  hit;

  assign rise = ev_r & ~ev_rr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ev_r    <= '0;
      ev_rr   <= '0;
      data_r  <= '0;
      data_rr <= '0;
      qual    <= 1'b0;
      ts      <= '0;
    end else begin
      ev_r    <= event_i;
      ev_rr   <= ev_r;
      data_r  <= data_i;
      data_rr <= data_r;
      qual    <= |(rise & trig_mask_i);
      ts      <= ts + 16'd1;
    end
  end

  // A fresh edge always reloads, so back-to-back pulses extend the visible window.
  for (genvar i = 0; i < 8; i++) begin : g_stretch
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stretch_cnt[i] <= '0;
      end else if (rise[i]) begin
        stretch_cnt[i] <= STRETCH_LOAD;
      end else if (stretch_cnt[i] != 4'd0) begin
        stretch_cnt[i] <= stretch_cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    stretched = '0;
    for (int i = 0; i < 8; i++) begin
      stretched[i] = (stretch_cnt[i] != 4'd0);
    end
  end

  // Arm has priority over a coincident qualified edge for both the hit count and the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      hold_cnt <= '0;
      hit      <= '0;
      frozen_o <= 1'b0;
    end else begin
      frozen_o <= (state == FROZEN);
      if (arm_i) begin
        hit <= '0;
      end else if (qual && state != FROZEN && hit != 3'd7) begin
        hit <= hit + 3'd1;
      end
      if (arm_i) begin
        state <= ARMED;
      end else begin
        case (state)
          IDLE: ;
          ARMED: begin
            if (qual) begin
              if (HOLDOFF == 0) begin
                state <= FROZEN;
              end else begin
                state    <= POST;
                hold_cnt <= HOLD_LOAD;
              end
            end
          end
          POST: begin
            if (hold_cnt == 16'd0) begin
              state <= FROZEN;
            end else begin
              hold_cnt <= hold_cnt - 16'd1;
            end
          end
          FROZEN: ;
        endcase
      end
    end
  end

  // The word is sampled from pre-transition values, so the frozen copy still shows POST (or ARMED).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      debug_o <= '0;
    end else if (state != FROZEN) begin
      debug_o <= {state, hit, ts, data_rr, stretched};
    end
  end

endmodule
